// File: rtl/output_port_unit.sv
// Router output port: round-robin ownership grant, packet FIFO and credit-controlled link driver.
// One instance sits behind each crossbar output column.
`timescale 1ns/1ps
module output_port_unit #(
  parameter int NUM_OF_PORTS = 5,
  parameter int FLIT_W       = 64,
  parameter int BUF_DEPTH    = 4,
  parameter int CREDITS      = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_OF_PORTS-1:0]         i_req,
  output logic [NUM_OF_PORTS-1:0]         o_ack,
  input  logic                            i_flit_valid,
  input  logic [1:0]                      i_flit_type,
  input  logic [FLIT_W-1:0]               i_flit,
  output logic                            o_buf_ready,
  output logic                            o_port_free,
  output logic [$clog2(NUM_OF_PORTS)-1:0] o_owner,
  output logic                            o_link_valid,
  output logic [1:0]                      o_link_type,
  output logic [FLIT_W-1:0]               o_link_flit,
  input  logic                            i_credit_ret,
  output logic [$clog2(CREDITS+1)-1:0]    o_credits,
  output logic                            o_overflow
);

  localparam int OW = $clog2(NUM_OF_PORTS);
  localparam int CW = $clog2(CREDITS+1);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam logic [1:0] TYPE_NONE = 2'b00;
  localparam logic [1:0] TYPE_TAIL = 2'b11;

  typedef enum logic [1:0] {IDLE, GRANT, ACTIVE, DRAIN} state_t;

  state_t                  state, state_nxt;
  logic [OW-1:0]           rr_ptr, owner, winner;
  logic [OW:0]             cand;
  logic                    found;
  logic [FLIT_W+1:0]       mem [BUF_DEPTH];
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [AW:0]             count;
  logic                    full, empty, pop, push_try, push, ovf_set;
  logic [CW-1:0]           credits;
  logic                    vld_p1, ovf;
  logic [1:0]              type_p1;
  logic [FLIT_W-1:0]       flit_p1;

  function automatic logic [CW-1:0] sat_credit(input logic [CW-1:0] c, input logic dec,
                                               input logic inc);
    logic [CW-1:0] r;
    r = c;
    if (dec && !inc) r = c - CW'(1);
    else if (inc && !dec && c != CW'(CREDITS)) r = c + CW'(1);
    return r;
  endfunction

  // first requester at or after the round-robin pointer, wrapping past the last input
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int i = 0; i < NUM_OF_PORTS; i++) begin
      cand = {1'b0, rr_ptr} + (OW+1)'(i);
      if (cand >= (OW+1)'(NUM_OF_PORTS)) cand = cand - (OW+1)'(NUM_OF_PORTS);
      if (!found && i_req[cand[OW-1:0]]) begin
        found  = 1'b1;
        winner = cand[OW-1:0];
      end
    end
  end

  assign full     = (count == (AW+1)'(BUF_DEPTH));
  assign empty    = (count == '0);
  assign pop      = !empty && (credits != '0);
  assign push_try = (state != IDLE) && i_flit_valid && (i_flit_type != TYPE_NONE);
  // a pop in the same cycle frees the slot, so a full FIFO can still accept
  assign push     = push_try && (!full || pop);
  assign ovf_set  = push_try && full && !pop;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = GRANT;
      GRANT:   state_nxt = ACTIVE;
      ACTIVE:  if (push_try && i_flit_type == TYPE_TAIL) state_nxt = DRAIN;
      DRAIN:   if (empty) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rr_ptr <= '0;
      owner  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && found) begin
        owner  <= winner;
        rr_ptr <= (winner == OW'(NUM_OF_PORTS-1)) ? '0 : winner + OW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {i_flit_type, i_flit};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      credits <= CW'(CREDITS);
      ovf     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
      credits <= sat_credit(credits, pop, i_credit_ret);
      if (ovf_set) ovf <= 1'b1;
    end
  end

  // link stage: popped flit appears one cycle after the pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      type_p1 <= TYPE_NONE;
      flit_p1 <= '0;
    end else begin
      vld_p1 <= pop;
      if (pop) {type_p1, flit_p1} <= mem[rd_ptr];
      else     type_p1 <= TYPE_NONE;
    end
  end

  assign o_ack        = (state == GRANT) ? (NUM_OF_PORTS'(1) << owner) : '0;
  assign o_port_free  = (state == IDLE);
  assign o_owner      = owner;
  assign o_buf_ready  = !full;
  assign o_link_valid = vld_p1;
  assign o_link_type  = type_p1;
  assign o_link_flit  = flit_p1;
  assign o_credits    = credits;
  assign o_overflow   = ovf;

endmodule

// File: tb/tb_output_port_unit.sv
// Bench for output_port_unit: expected link flits are queued at stimulus time and a monitor
// pops and compares them as the link presents flits; credits follow a counting model.
`timescale 1ns/1ps
module tb_output_port_unit;
  localparam int N  = 5;
  localparam int FW = 64;
  localparam int BD = 4;
  localparam int CR = 4;

  logic          clk, rst_n;
  logic [N-1:0]  i_req, o_ack;
  logic          i_flit_valid, o_buf_ready, o_port_free, o_link_valid, i_credit_ret, o_overflow;
  logic [1:0]    i_flit_type, o_link_type;
  logic [FW-1:0] i_flit, o_link_flit;
  logic [2:0]    o_owner;
  logic [2:0]    o_credits;

  output_port_unit #(.NUM_OF_PORTS(N), .FLIT_W(FW), .BUF_DEPTH(BD), .CREDITS(CR)) dut (
    .clk(clk), .rst_n(rst_n), .i_req(i_req), .o_ack(o_ack),
    .i_flit_valid(i_flit_valid), .i_flit_type(i_flit_type), .i_flit(i_flit),
    .o_buf_ready(o_buf_ready), .o_port_free(o_port_free), .o_owner(o_owner),
    .o_link_valid(o_link_valid), .o_link_type(o_link_type), .o_link_flit(o_link_flit),
    .i_credit_ret(i_credit_ret), .o_credits(o_credits), .o_overflow(o_overflow));

  typedef struct { logic [1:0] t; logic [FW-1:0] d; } item_t;
  item_t exp_q[$];
  int total = 0, bad = 0;
  int link_seen = 0;
  int m_cred = CR;
  bit p_ret = 0;
  int rr_m = 0;

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor and credit model
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_cred = CR;
      p_ret  = 0;
    end else begin
      if (o_link_valid) begin
        link_seen++;
        if (exp_q.size() == 0) chk("link_unexpected", 1, 0);
        else begin
          item_t e;
          e = exp_q.pop_front();
          chk("link_type", o_link_type, e.t);
          chk("link_flit", o_link_flit, e.d);
        end
      end else chk("link_idle_type", o_link_type, 0);
      m_cred = m_cred - (o_link_valid ? 1 : 0) + (p_ret ? 1 : 0);
      if (m_cred > CR) m_cred = CR;
      chk("credits", o_credits, m_cred);
      p_ret = i_credit_ret;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] t, input bit expect_it);
    i_flit_valid = 1;
    i_flit_type  = t;
    i_flit       = {$urandom, $urandom};
    if (expect_it) exp_q.push_back('{t, i_flit});
  endtask

  task automatic no_flit;
    i_flit_valid = 0;
    i_flit_type  = 2'b00;
  endtask

  // request in IDLE; returns in the GRANT cycle
  task automatic grant(input logic [N-1:0] mask);
    int w;
    w = -1;
    for (int i = 0; i < N; i++) begin
      int k;
      k = (rr_m + i) % N;
      if (w < 0 && mask[k]) w = k;
    end
    i_req = mask;
    tick;
    i_req = '0;
    chk("ack", o_ack, 64'(1) << w);
    chk("owner", o_owner, w);
    chk("port_busy", o_port_free, 0);
    rr_m = (w + 1) % N;
  endtask

  task automatic wait_free(input int ret_cycles);
    int n;
    no_flit;
    for (int i = 0; i < ret_cycles; i++) begin
      i_credit_ret = 1;
      tick;
    end
    i_credit_ret = 0;
    n = 0;
    while (!o_port_free && n < 200) begin
      tick;
      n++;
    end
    if (n >= 200) chk("free_timeout", 0, 1);
  endtask

  task automatic rand_packet;
    int len, sent, guard;
    grant(5'($urandom_range(1, 31)));
    len = $urandom_range(2, 6);
    sent = 0;
    guard = 0;
    while (sent < len && guard < 300) begin
      i_credit_ret = $urandom_range(0, 1);
      if (o_buf_ready && $urandom_range(0, 3) != 0) begin
        drive(sent == 0 ? 2'b01 : (sent == len-1 ? 2'b11 : 2'b10), 1);
        sent++;
      end else no_flit;
      tick;
      guard++;
    end
    if (guard >= 300) chk("rand_send_timeout", 0, 1);
    wait_free(CR + 2);
  endtask

  initial begin
    int base;
    rst_n = 0; i_req = '0; i_flit_valid = 0; i_flit_type = 2'b00; i_flit = '0; i_credit_ret = 0;
    repeat (3) tick;
    chk("rst_port_free", o_port_free, 1);
    chk("rst_ack", o_ack, 0);
    chk("rst_buf_ready", o_buf_ready, 1);
    chk("rst_link_valid", o_link_valid, 0);
    chk("rst_credits", o_credits, CR);
    chk("rst_overflow", o_overflow, 0);
    rst_n = 1;
    tick;
    // flits while IDLE are dropped
    drive(2'b01, 0); tick;
    drive(2'b11, 0); tick;
    no_flit; repeat (3) tick;
    chk("idle_drop_free", o_port_free, 1);

    // 4-flit packet, first grant
    grant(5'b00101);
    drive(2'b01, 1); tick;
    chk("ack_one_cycle", o_ack, 0);
    drive(2'b10, 1); tick;
    chk("t3_head_valid", o_link_valid, 1);
    chk("t3_head_type", o_link_type, 2'b01);
    drive(2'b10, 1); tick;
    drive(2'b11, 1); tick;
    no_flit; tick;
    chk("t3_tail_valid", o_link_valid, 1);
    chk("t3_tail_type", o_link_type, 2'b11);
    chk("t3_busy_at_tail", o_port_free, 0);
    tick;
    chk("t3_free", o_port_free, 1);
    chk("t3_link_done", o_link_valid, 0);
    chk("t3_credits0", o_credits, 0);
    wait_free(CR + 2);

    // round-robin advances past previous winner
    grant(5'b00101);
    drive(2'b01, 1); tick;
    drive(2'b11, 1); tick;
    wait_free(0);
    chk("t5_pre_credits", o_credits, 2);

    // pop and return in the same cycle at credits 2
    grant(5'b00010);
    drive(2'b01, 1); tick;
    i_credit_ret = 1;
    for (int i = 1; i < 6; i++) begin
      drive(i == 5 ? 2'b11 : 2'b10, 1);
      tick;
    end
    no_flit; tick;
    i_credit_ret = 0;
    chk("t5_credits_hold", o_credits, 2);
    wait_free(0);
    i_credit_ret = 1; tick; tick;
    chk("t5_credits_full", o_credits, CR);
    tick;
    i_credit_ret = 0;
    chk("t5_credits_sat", o_credits, CR);

    // credit stall with a 6-flit packet
    grant(5'b11111);
    base = link_seen;
    for (int i = 0; i < 6; i++) begin
      drive(i == 0 ? 2'b01 : (i == 5 ? 2'b11 : 2'b10), 1);
      tick;
    end
    no_flit; repeat (8) tick;
    chk("t4_stalled_count", link_seen - base, 4);
    chk("t4_stalled_busy", o_port_free, 0);
    i_credit_ret = 1; tick;
    i_credit_ret = 0; repeat (6) tick;
    chk("t4_one_more", link_seen - base, 5);
    wait_free(CR + 2);

    repeat (6) rand_packet;

    // drain credits to zero, then overflow the FIFO
    grant(5'($urandom_range(1, 31)));
    drive(2'b01, 1); tick;
    drive(2'b10, 1); tick;
    drive(2'b10, 1); tick;
    drive(2'b11, 1); tick;
    wait_free(0);
    chk("t6_credits0", o_credits, 0);
    grant(5'($urandom_range(1, 31)));
    drive(2'b01, 1); tick;
    drive(2'b10, 1); tick;
    drive(2'b10, 1); tick;
    chk("t6_ready_before_full", o_buf_ready, 1);
    drive(2'b10, 1); tick;
    chk("t6_ready_full", o_buf_ready, 0);
    chk("t6_no_ovf_yet", o_overflow, 0);
    drive(2'b10, 0); tick;
    no_flit;
    chk("t6_overflow", o_overflow, 1);
    chk("t6_still_full", o_buf_ready, 0);
    tick;
    chk("t6_overflow_sticky", o_overflow, 1);

    // asynchronous reset mid-packet
    #2 rst_n = 0;
    #1;
    chk("t1_port_free", o_port_free, 1);
    chk("t1_ack", o_ack, 0);
    chk("t1_owner", o_owner, 0);
    chk("t1_buf_ready", o_buf_ready, 1);
    chk("t1_link_valid", o_link_valid, 0);
    chk("t1_link_type", o_link_type, 0);
    chk("t1_link_flit", o_link_flit, 0);
    chk("t1_credits", o_credits, CR);
    chk("t1_overflow", o_overflow, 0);
    rr_m = 0;
    repeat (2) tick;
    rst_n = 1;
    tick;
    grant(5'b11000);
    drive(2'b01, 1); tick;
    drive(2'b11, 1); tick;
    wait_free(0);
    repeat (4) tick;
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
